// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: row strobes, column sense and key outputs.
// master: scanner side; slave: keypad/display side.
interface keypad_scanner_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  col_n,
    output row_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output col_n,
    input  row_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with tick-based debounce.
// Ports: clk2, rst_n (async, active-low), bus (keypad_scanner_if.master).
module keypad_scanner #(
  parameter int CLK_HZ   = 12_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int DB_TICKS = 4
) (
  input  logic             clk2,
  input  logic             rst_n,
  keypad_scanner_if.master bus
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [4:0]    DB       = 5'(DB_TICKS);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  logic [3:0]    sync1;
  logic [3:0]    cs;
  logic [DW-1:0] div_q;
  logic          tick;

  state_t     state_q, state_d;
  logic [1:0] r_q, r_d;
  logic [1:0] c_q, c_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] code_q, code_d;
  logic       held_q, held_d;
  logic       valid_q, valid_d;
  logic [3:0] row_q;

  logic       any_low;
  logic [1:0] low_col;
  logic       col_hi;
  logic [4:0] cnt_inc;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'b1111;
      cs    <= 4'b1111;
    end else begin
      sync1 <= bus.col_n;
      cs    <= sync1;
    end
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Lowest-index low column wins ties within a row.
  always_comb begin
    low_col = 2'd0;
    if (!cs[3]) low_col = 2'd3;
    if (!cs[2]) low_col = 2'd2;
    if (!cs[1]) low_col = 2'd1;
    if (!cs[0]) low_col = 2'd0;
  end

  assign any_low = ~&cs;
  assign col_hi  = cs[c_q];
  // One bit wider so the >= test cannot wrap at 15.
  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    held_d  = held_q;
    valid_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (any_low) begin
            c_d     = low_col;
            cnt_d   = 4'd1;
            state_d = DEBOUNCE;
          end else begin
            r_d = r_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!col_hi) begin
            cnt_d = cnt_inc[3:0];
            if (cnt_inc >= DB) begin
              code_d  = {r_q, c_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = HELD;
            end
          end else begin
            state_d = SCAN;
            r_d     = r_q + 2'd1;
          end
        end
        HELD: begin
          if (col_hi) begin
            cnt_d   = 4'd1;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (col_hi) begin
            cnt_d = cnt_inc[3:0];
            if (cnt_inc >= DB) begin
              held_d  = 1'b0;
              state_d = SCAN;
              r_d     = r_q + 2'd1;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      r_q     <= 2'd0;
      c_q     <= 2'd0;
      cnt_q   <= 4'd0;
      code_q  <= 4'd0;
      held_q  <= 1'b0;
      valid_q <= 1'b0;
      row_q   <= 4'b1110;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      held_q  <= held_d;
      valid_q <= valid_d;
      row_q   <= ~(4'b0001 << r_d);
    end
  end

  assign bus.row_n     = row_q;
  assign bus.key_code  = code_q;
  assign bus.key_valid = valid_q;
  assign bus.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a 4x4 keypad model.
// DIV=10, DB_TICKS=3; expected codes queued at stimulus time.
module tb_keypad_scanner;

  logic        clk2;
  logic        rst_n;
  logic [15:0] pressed;
  logic [3:0]  col_model;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  keypad_scanner_if bus();

  keypad_scanner #(
    .CLK_HZ(1000),
    .SCAN_HZ(100),
    .DB_TICKS(3)
  ) dut (
    .clk2(clk2),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  always_comb begin
    col_model = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!bus.row_n[r] && pressed[r*4+c])
          col_model[c] = 1'b0;
  end

  assign bus.col_n = col_model;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_held(input logic v, input int lim,
                           input string name);
    int n = 0;
    while (bus.key_held !== v && n < lim) begin
      @(negedge clk2);
      n++;
    end
    check(name, {31'd0, bus.key_held}, {31'd0, v});
  endtask

  task automatic wait_row_change(input string name);
    logic [3:0] r0;
    int n = 0;
    r0 = bus.row_n;
    while (bus.row_n === r0 && n < 30) begin
      @(negedge clk2);
      n++;
    end
    check(name, {31'd0, bus.row_n !== r0}, 32'd1);
  endtask

  task automatic wait_row_enter(input logic [3:0] v,
                                input string name);
    logic [3:0] prev;
    logic found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      prev = bus.row_n;
      @(negedge clk2);
      if (bus.row_n === v && prev !== v) found = 1'b1;
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  // Monitor: every key_valid pulse must match the queue head.
  initial begin
    logic prev_v = 1'b0;
    logic [3:0] e;
    forever begin
      @(negedge clk2);
      if (rst_n && bus.key_valid === 1'b1) begin
        if (prev_v) begin
          checks++;
          errors++;
          $display("FAIL pulse_width: valid high 2 cycles, required 1");
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: code %0h, required no pulse",
                   bus.key_code);
        end else begin
          e = exp_q.pop_front();
          check("key_code_on_valid", {28'd0, bus.key_code}, {28'd0, e});
        end
      end
      prev_v = bus.key_valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    pressed = 16'h0;
    repeat (3) @(negedge clk2);
    rst_n = 1'b1;
    #1;
    check("rst_row_n", {28'd0, bus.row_n}, 32'hE);
    check("rst_key_code", {28'd0, bus.key_code}, 32'h0);
    check("rst_key_valid", {31'd0, bus.key_valid}, 32'd0);
    check("rst_key_held", {31'd0, bus.key_held}, 32'd0);
    repeat (9) @(negedge clk2);
    check("row_step_pre", {28'd0, bus.row_n}, 32'hE);
    @(negedge clk2);
    check("row_step1", {28'd0, bus.row_n}, 32'hD);
    repeat (10) @(negedge clk2);
    check("row_step2", {28'd0, bus.row_n}, 32'hB);
    repeat (10) @(negedge clk2);
    check("row_step3", {28'd0, bus.row_n}, 32'h7);
    repeat (10) @(negedge clk2);
    check("row_step4", {28'd0, bus.row_n}, 32'hE);

    // Single press/release of (2,1)
    exp_q.push_back(4'd9);
    pressed[9] = 1'b1;
    repeat (200) @(negedge clk2);
    check("t2_held", {31'd0, bus.key_held}, 32'd1);
    check("t2_code", {28'd0, bus.key_code}, 32'h9);
    pressed[9] = 1'b0;
    wait_held(1'b0, 60, "t2_release");
    wait_row_change("t2_scan_resume");
    repeat (60) @(negedge clk2);

    // Bounce on (0,3): low across one tick only
    wait_row_enter(4'hE, "t3_row0");
    pressed[3] = 1'b1;
    repeat (15) @(negedge clk2);
    pressed[3] = 1'b0;
    repeat (20) @(negedge clk2);
    check("t3_code_kept", {28'd0, bus.key_code}, 32'h9);
    check("t3_not_held", {31'd0, bus.key_held}, 32'd0);
    wait_row_change("t3_scan_resume");

    // Simultaneous (1,0) and (1,3), then (3,3) extra
    exp_q.push_back(4'd4);
    pressed[4] = 1'b1;
    pressed[7] = 1'b1;
    repeat (150) @(negedge clk2);
    check("t4_code", {28'd0, bus.key_code}, 32'h4);
    check("t4_held", {31'd0, bus.key_held}, 32'd1);
    pressed[15] = 1'b1;
    repeat (150) @(negedge clk2);
    check("t4_code_kept", {28'd0, bus.key_code}, 32'h4);
    pressed = 16'h0;
    wait_held(1'b0, 60, "t4_release");
    repeat (40) @(negedge clk2);

    // Release glitch of two ticks on (2,1)
    exp_q.push_back(4'd9);
    pressed[9] = 1'b1;
    repeat (150) @(negedge clk2);
    check("t5_held", {31'd0, bus.key_held}, 32'd1);
    pressed[9] = 1'b0;
    repeat (20) @(negedge clk2);
    pressed[9] = 1'b1;
    check("t5_held_glitch", {31'd0, bus.key_held}, 32'd1);
    repeat (60) @(negedge clk2);
    check("t5_held_after", {31'd0, bus.key_held}, 32'd1);

    // Reset while held, key stays pressed
    rst_n = 1'b0;
    #1;
    check("t6_row_n", {28'd0, bus.row_n}, 32'hE);
    check("t6_code", {28'd0, bus.key_code}, 32'h0);
    check("t6_valid", {31'd0, bus.key_valid}, 32'd0);
    check("t6_held", {31'd0, bus.key_held}, 32'd0);
    repeat (3) @(negedge clk2);
    exp_q.push_back(4'd9);
    rst_n = 1'b1;
    repeat (150) @(negedge clk2);
    check("t6_rearm_held", {31'd0, bus.key_held}, 32'd1);
    check("t6_rearm_code", {28'd0, bus.key_code}, 32'h9);
    pressed = 16'h0;
    wait_held(1'b0, 60, "t6_release");
    repeat (40) @(negedge clk2);

    check("pending_expected", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces the detected key in the scan time base, and delivers a 4-bit hex key code with a one-cycle valid strobe. The block drives the row strobes and reads the columns. It feeds the hex-counter / seven-segment display path with key codes 0x0–0xF instead of single push-button edges.

## Interface
- CLK_HZ, 12_000_000: clk2 frequency in Hz.
- SCAN_HZ, 1000: scan tick rate in Hz.
  - DIV = CLK_HZ/SCAN_HZ clk2 cycles per tick; DIV ≥ 2.
- DB_TICKS, 4: consecutive identical ticks required to accept a press or a release; range 1..15.

- clk2  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- col_n  in  4  keypad columns, active-low, externally pulled up, asynchronous to clk2.
- row_n  out  4  row strobes, active-low one-hot.
- key_code  out  4  last accepted key; code = row*4 + col.
- key_valid  out  1  one clk2 pulse per accepted press.
- key_held  out  1  high while the accepted key is pressed.

## Operation
- **Column synchroniser:** col_n passes through a 2-flop synchroniser. All decisions use the synchronised value, called cs.
- **Tick generator:** counter of width $clog2(DIV), counting 0..DIV-1. tick = 1 for one cycle when the counter equals DIV-1; the counter then wraps to 0.
- **Row index r:** rows selected as row_n = ~(4'b0001 << r).
- **Latched position:** (r, c) holds the row and column of the candidate or accepted key.
- **Debounce counter:** 4 bits.
- **Reset values:** state SCAN, r=0, row_n=4'b1110, key_code=0, key_valid=0, key_held=0, divider=0, debounce counter=0, synchroniser flops=4'b1111.
- **FSM (all transitions evaluated only on tick cycles, except the key_valid clear):**
  - **SCAN**
    - If any cs bit is 0: latch c = lowest-index low column, set cnt=1, go to DEBOUNCE. r is not advanced.
    - Otherwise: r ← r+1 mod 4 (3 wraps to 0).
  - **DEBOUNCE**
    - If cs[c]=0: cnt++.
      - When cnt reaches DB_TICKS: key_code ← {r,c}, key_valid=1 for exactly one clk2 cycle, key_held ← 1, go to HELD.
    - If cs[c]=1: go to SCAN and advance r. No output change.
    - DB_TICKS=1: accept on the first tick after entry.
  - **HELD**
    - If cs[c]=1: cnt=1, go to RELEASE.
    - Otherwise stay. Other keys are ignored.
  - **RELEASE**
    - If cs[c]=1: cnt++.
      - When cnt reaches DB_TICKS: key_held ← 0, go to SCAN, advance r.
    - If cs[c]=0: return to HELD. No new key_valid.
- **Row stability:** row_n changes only on tick cycles. Rows are frozen in DEBOUNCE, HELD and RELEASE.
- **Multiple keys:**
  - Only the first key found by the scan is tracked.
  - Ties within a row go to the lowest column.
  - Additional keys never produce key_valid until the tracked key is released.
- **key_code** holds its value until the next accepted press.
- **Reset mid-operation:** reset in any state immediately forces the reset values. No key_valid is emitted.

## Timing
- row_n is registered and changes in the cycle after a tick.
- Column settle time is one full tick period (DIV cycles) before the next sample.
- **Press latency:**
  - key_valid and key_code are registered together, one cycle after the accepting tick.
  - From a stable press to key_valid: at most (3 + DB_TICKS) ticks + 3 clk2 cycles.
- **Release latency:** key_held falls one cycle after the DB_TICKS-th consecutive released tick.
- **Pulse spacing:** key_valid pulses are separated by at least 2·DB_TICKS ticks.
- **Synchroniser sampling:** a column change inside a tick period is visible at the next tick only if it precedes that tick by ≥2 cycles.

## Test plan
Bench parameters: CLK_HZ=1000, SCAN_HZ=100 (DIV=10), DB_TICKS=3. The bench keypad model drives col_n[c]=0 when row_n[r]=0 and key (r,c) is pressed.

1. **Reset / idle:**
   - Assert rst_n=0, then release with no keys pressed.
   - Required: row_n=1110, key_code=0, key_valid=0, key_held=0.
   - Required: row_n then steps 1101, 1011, 0111, 1110, one step every 10 cycles.
2. **Single press and release:**
   - Hold key (2,1) for 200 cycles, then release.
   - Required: exactly one key_valid pulse with key_code=9, key_held=1.
   - Required: key_held=0 three ticks after release; scanning resumes; no second pulse.
3. **Bounce rejection:** key (0,3) low for one tick, then high. Required: no key_valid, key_code unchanged, row scanning resumes.
4. **Simultaneous keys:** press (1,0) and (1,3) together. Required: key_code=4. Pressing (3,3) while (1,0) is held gives no pulse.
5. **Release glitch:** while held, key (2,1) reads high for 2 ticks and then low again. Required: key_held stays 1 and no new key_valid.
6. **Reset mid-HELD:** assert rst_n while key_held=1. Required: all outputs return to reset values at once. After rst_n releases with the key still pressed, a fresh press is detected and key_valid is emitted.
